pass_check_fsm: RTL and testbench

//  Clocked, parametrised password checker for the digital lock; successor to the combinational default-password check.
//  - Collects DIGITS digits, one per enter press, and compares them against the stored password or the default password.
//  - Drives the unlock output Q and counts failed attempts; after MAX_TRIES failures it enters a timed lockout.
//  - Lets an unlocked user program a new stored password.
//  - Sits between the debounced button/switch front end and the LED/lock-actuator outputs.

---
 rtl/pass_check_fsm.sv | 117 +++++++++++
 tb/tb_pass_check_fsm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pass_check_fsm.sv
// pass_check_fsm: clocked password checker with failure lockout and password programming.
// Define PASS_TIMEOUT_EN to discard a partial entry after TIMEOUT_CYC idle cycles.
module pass_check_fsm #(
  parameter int DIGITS = 4,
  parameter int DIGIT_W = 2,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter logic [DIGITS*DIGIT_W-1:0] DEF_PASS = 8'b01101100
) (
  input  logic                             clk,
  input  logic                             rst_all_n,
  input  logic                             mode,
  input  logic                             mode_def,
  input  logic                             enter,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             lock_rst,
  output logic                             Q,
  output logic [$clog2(MAX_TRIES+1)-1:0]   led_fail,
  output logic                             locked_out,
  output logic [$clog2(DIGITS+1)-1:0]      digit_cnt,
  output logic                             pw_saved
);
  localparam int PW = DIGITS * DIGIT_W;
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);
  localparam logic [FW-1:0] MAXF = FW'(MAX_TRIES);
  localparam logic [LW-1:0] LOAD = LW'(LOCKOUT_CYC);
  localparam logic [2:0] IDLE = 3'd0, COLLECT = 3'd1, COMPARE = 3'd2, OPEN = 3'd3, SETPW = 3'd4, LOCKOUT = 3'd5;
  logic [2:0] state;
  logic enter_q, rise, full, match, timeout;
  logic [PW-1:0] shift, stored, shifted, ref_pw;
  logic [CW-1:0] cnt_nxt;
  logic [LW-1:0] lock_cnt;
  assign rise = enter & ~enter_q;
  assign shifted = (shift << DIGIT_W) | PW'(digit_in);
  assign cnt_nxt = digit_cnt + 1'b1;
  assign full = cnt_nxt == FULL;
  assign ref_pw = mode_def ? DEF_PASS : stored;
  assign match = shift == ref_pw;
  assign Q = state == OPEN || state == SETPW;
  assign locked_out = state == LOCKOUT;
`ifdef PASS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  logic busy;
  assign busy = state == COLLECT || state == SETPW;
  assign timeout = busy && !rise && idle_cnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_all_n)
    if (!rst_all_n) idle_cnt <= '0;
    else idle_cnt <= (busy && !rise && !timeout) ? idle_cnt + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_all_n)
    if (!rst_all_n) begin
      state <= IDLE;
      enter_q <= 1'b0;
      shift <= '0;
      digit_cnt <= '0;
      led_fail <= '0;
      stored <= DEF_PASS;
      lock_cnt <= '0;
      pw_saved <= 1'b0;
    end else begin
      enter_q <= enter;
      pw_saved <= 1'b0;
      if (state == LOCKOUT) begin
        lock_cnt <= lock_cnt - 1'b1;
        if (lock_cnt < LW'(2)) begin
          state <= IDLE;
          led_fail <= '0;
        end
      end else if (lock_rst || timeout) begin
        // a timeout in SETPW keeps the user unlocked; lock_rst always relocks
        state <= (state == SETPW && !lock_rst) ? OPEN : IDLE;
        shift <= '0;
        digit_cnt <= '0;
      end else
        case (state)
          IDLE, COLLECT:
            if (rise) begin
              shift <= shifted;
              digit_cnt <= cnt_nxt;
              state <= full ? COMPARE : COLLECT;
            end
          COMPARE: begin
            shift <= '0;
            digit_cnt <= '0;
            if (match) begin
              state <= OPEN;
              led_fail <= '0;
              if (mode_def) stored <= DEF_PASS;
            end else begin
              led_fail <= led_fail + 1'b1;
              state <= (led_fail == MAXF - 1'b1) ? LOCKOUT : IDLE;
              lock_cnt <= LOAD;
            end
          end
          OPEN, SETPW:
            if (state == SETPW && !mode) begin
              state <= OPEN;
              shift <= '0;
              digit_cnt <= '0;
            end else if (rise && mode) begin
              shift <= full ? '0 : shifted;
              digit_cnt <= full ? '0 : cnt_nxt;
              state <= full ? OPEN : SETPW;
              pw_saved <= full;
              if (full) stored <= shifted;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_pass_check_fsm.sv
// tb_pass_check_fsm: directed test of pass_check_fsm with default parameters (DEF_PASS = 1,2,3,0).
module tb_pass_check_fsm;
  logic clk = 1'b0, rst_all_n = 1'b0, mode = 1'b0, mode_def = 1'b0, enter = 1'b0, lock_rst = 1'b0;
  logic [1:0] digit_in = 2'd0;
  logic Q, locked_out, pw_saved;
  logic [1:0] led_fail;
  logic [2:0] digit_cnt;
  int n_checks = 0, n_fail = 0, n;

  pass_check_fsm dut (
    .clk(clk), .rst_all_n(rst_all_n), .mode(mode), .mode_def(mode_def), .enter(enter),
    .digit_in(digit_in), .lock_rst(lock_rst), .Q(Q), .led_fail(led_fail),
    .locked_out(locked_out), .digit_cnt(digit_cnt), .pw_saved(pw_saved)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic press(input logic [1:0] d);
    @(negedge clk);
    digit_in = d;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic entry(input logic [1:0] a, b, c, d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  task automatic settle;
    repeat (2) @(negedge clk);
  endtask

  task automatic relock;
    @(negedge clk);
    lock_rst = 1'b1;
    @(negedge clk);
    lock_rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_q", 32'(Q), 0);
    check("rst_fail", 32'(led_fail), 0);
    check("rst_lock", 32'(locked_out), 0);
    check("rst_cnt", 32'(digit_cnt), 0);
    check("rst_saved", 32'(pw_saved), 0);
    rst_all_n = 1'b1;
    // default password opens the lock
    press(1); press(2); press(3);
    check("t1_cnt3", 32'(digit_cnt), 3);
    press(0);
    check("t1_cnt4", 32'(digit_cnt), 4);
    check("t1_q_early", 32'(Q), 0);
    settle;
    check("t1_q", 32'(Q), 1);
    check("t1_fail", 32'(led_fail), 0);
    relock;
    check("relock_q", 32'(Q), 0);
    // three failures lead to lockout
    entry(1, 2, 3, 1);
    settle;
    check("t2_fail1", 32'(led_fail), 1);
    check("t2_q1", 32'(Q), 0);
    entry(1, 2, 3, 1);
    settle;
    check("t2_fail2", 32'(led_fail), 2);
    entry(1, 2, 3, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n += int'(locked_out);
      digit_in = 2'd1;
      enter = (i < 8) && !i[0];
      lock_rst = i == 3;
    end
    enter = 1'b0;
    lock_rst = 1'b0;
    check("t2_lock_cycles", 32'(n), 16);
    check("t2_lock_end", 32'(locked_out), 0);
    check("t2_fail_clr", 32'(led_fail), 0);
    check("t2_cnt_ignored", 32'(digit_cnt), 0);
    // program a new password
    entry(1, 2, 3, 0);
    settle;
    check("t3_open", 32'(Q), 1);
    mode = 1'b1;
    press(3); press(3); press(0); press(1);
    check("t3_saved", 32'(pw_saved), 1);
    check("t3_q_setpw", 32'(Q), 1);
    check("t3_cnt", 32'(digit_cnt), 0);
    @(negedge clk);
    check("t3_saved_pulse", 32'(pw_saved), 0);
    mode = 1'b0;
    relock;
    entry(3, 3, 0, 1);
    settle;
    check("t3_new_pw", 32'(Q), 1);
    relock;
    entry(1, 2, 3, 0);
    settle;
    check("t3_old_pw_q", 32'(Q), 0);
    check("t3_old_pw_fail", 32'(led_fail), 1);
    // default password with mode_def restores the stored password
    mode_def = 1'b1;
    entry(1, 2, 3, 0);
    settle;
    check("def_q", 32'(Q), 1);
    check("def_fail", 32'(led_fail), 0);
    mode_def = 1'b0;
    relock;
    entry(1, 2, 3, 0);
    settle;
    check("def_reload", 32'(Q), 1);
    relock;
    // lock_rst beats a simultaneous enter edge
    entry(0, 0, 0, 0);
    settle;
    check("t4_fail", 32'(led_fail), 1);
    press(1); press(2);
    check("t4_cnt2", 32'(digit_cnt), 2);
    @(negedge clk);
    lock_rst = 1'b1;
    enter = 1'b1;
    digit_in = 2'd3;
    @(negedge clk);
    lock_rst = 1'b0;
    enter = 1'b0;
    check("t4_cnt0", 32'(digit_cnt), 0);
    check("t4_fail_kept", 32'(led_fail), 1);
    entry(1, 2, 3, 0);
    settle;
    check("t4_after", 32'(Q), 1);
    // change password, then async reset must restore the default
    mode = 1'b1;
    entry(2, 2, 2, 2);
    mode = 1'b0;
    relock;
    entry(0, 0, 0, 0);
    settle;
    check("t5_fail", 32'(led_fail), 1);
    @(negedge clk);
    digit_in = 2'd1;
    enter = 1'b1;
    repeat (10) @(negedge clk);
    enter = 1'b0;
    check("t5_held", 32'(digit_cnt), 1);
    press(2); press(3);
    check("t5_cnt3", 32'(digit_cnt), 3);
    @(negedge clk);
    #2 rst_all_n = 1'b0;
    #1;
    check("t5_arst_cnt", 32'(digit_cnt), 0);
    check("t5_arst_fail", 32'(led_fail), 0);
    check("t5_arst_q", 32'(Q), 0);
    @(negedge clk);
    rst_all_n = 1'b1;
    entry(1, 2, 3, 0);
    settle;
    check("t5_def_back", 32'(Q), 1);
    relock;
    // idle partial entry
    entry(0, 0, 0, 0);
    settle;
    press(1); press(2);
    repeat (70) @(negedge clk);
`ifdef PASS_TIMEOUT_EN
    check("t6_timeout_cnt", 32'(digit_cnt), 0);
`else
    check("t6_persist_cnt", 32'(digit_cnt), 2);
`endif
    check("t6_fail_kept", 32'(led_fail), 1);
    check("t6_q", 32'(Q), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
